contador_checker: RTL and testbench

Synthesizable receive-side checker for the 4-bit `contador`. It observes the counter's control inputs (enable, mode, D) and its outputs (Q, load, rco) on the shared bench clock. It runs a cycle-accurate reference model and flags any mismatch. It sits beside the DUT in `tb_top`, driven by the same wires as the DUT, and also synthesizes for the FPGA self-test wrapper.

---
 rtl/contador_checker.sv | 112 +++++++++++
 tb/tb_contador_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/contador_checker.sv
// contador_checker: cycle-accurate reference model and mismatch checker for the 4-bit contador.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   enable, mode, D    counter controls as driven to the DUT
//   Q, load, rco       DUT outputs under check (Q[0] is the MSB)
//   exp_q              model count, same bit order as Q
//   armed              comparisons active
//   err_q/load/rco     one-cycle mismatch pulses per field
//   err                sticky OR of all mismatches since reset
//   err_count          saturating count of mismatching cycles
//   chk_count          saturating count of compared cycles
module contador_checker #(
   parameter int ERR_CNT_W   = 8,
   parameter int CHK_CNT_W   = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic [3:0]           D,
   input  logic [0:3]           Q,
   input  logic                 load,
   input  logic                 rco,
   output logic [0:3]           exp_q,
   output logic                 armed,
   output logic                 err_q,
   output logic                 err_load,
   output logic                 err_rco,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [CHK_CNT_W-1:0] chk_count
);

   typedef enum logic [1:0] {M_INC, M_DEC, M_DEC3, M_LOAD} mode_e;

   logic [3:0]           cnt_q, cnt_d;
   logic                 ld_q, ld_d;
   logic                 wrap_q, wrap_d;
   logic                 armed_q;
   logic                 mq_q, ml_q, mr_q;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] errc_q, errc_d;
   logic [CHK_CNT_W-1:0] chkc_q, chkc_d;
   logic                 frozen, cmp, mis_q, mis_load, mis_rco, mis_any;

   // Once frozen, the model and counters stop and no further compares happen.
   assign frozen   = STOP_ON_ERR && sticky_q;
   // armed_q rises on the first clean edge, so that edge itself never compares.
   assign cmp      = armed_q && !frozen;
   // Q and the model hold the result of the previous edge; rco is still high
   // here from the low phase when the previous edge wrapped.
   assign mis_q    = cmp && (Q != cnt_q);
   assign mis_load = cmp && (load != ld_q);
   assign mis_rco  = cmp && (rco != wrap_q);
   assign mis_any  = mis_q || mis_load || mis_rco;

   always_comb begin
      cnt_d  = cnt_q;
      ld_d   = 1'b0;
      wrap_d = 1'b0;
      if (enable) begin
         case (mode_e'(mode))
            M_INC:   begin cnt_d = cnt_q + 4'd1; wrap_d = (cnt_q == 4'd15); end
            M_DEC:   begin cnt_d = cnt_q - 4'd1; wrap_d = (cnt_q == 4'd0);  end
            M_DEC3:  begin cnt_d = cnt_q - 4'd3; wrap_d = (cnt_q < 4'd3);   end
            default: begin cnt_d = D;            ld_d   = 1'b1;             end
         endcase
      end
      sticky_d = sticky_q || mis_any;
      chkc_d   = (cmp && !(&chkc_q)) ? chkc_q + CHK_CNT_W'(1) : chkc_q;
      errc_d   = (mis_any && !(&errc_q)) ? errc_q + ERR_CNT_W'(1) : errc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         ld_q     <= 1'b0;
         wrap_q   <= 1'b0;
         armed_q  <= 1'b0;
         mq_q     <= 1'b0;
         ml_q     <= 1'b0;
         mr_q     <= 1'b0;
         sticky_q <= 1'b0;
         errc_q   <= '0;
         chkc_q   <= '0;
      end else begin
         armed_q  <= 1'b1;
         mq_q     <= mis_q;
         ml_q     <= mis_load;
         mr_q     <= mis_rco;
         sticky_q <= sticky_d;
         errc_q   <= errc_d;
         chkc_q   <= chkc_d;
         if (!frozen) begin
            cnt_q  <= cnt_d;
            ld_q   <= ld_d;
            wrap_q <= wrap_d;
         end
      end
   end

   assign exp_q     = cnt_q;
   assign armed     = armed_q;
   assign err_q     = mq_q;
   assign err_load  = ml_q;
   assign err_rco   = mr_q;
   assign err       = sticky_q;
   assign err_count = errc_q;
   assign chk_count = chkc_q;

endmodule

// File: tb/tb_contador_checker.sv
// tb_contador_checker: directed bench for contador_checker with a fault-injectable counter stand-in.
module tb_contador_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [3:0]  D = 4'd0;
   logic        flip = 1'b0;
   logic        stuck = 1'b0;
   logic [3:0]  cnt;
   logic        ld, wrp, rco_r;
   logic [0:3]  Q;

   logic [0:3]  a_exp, s_exp;
   logic        a_armed, a_eq, a_el, a_er, a_err;
   logic        s_armed, s_eq, s_el, s_er, s_err;
   logic [7:0]  a_errc, s_errc;
   logic [15:0] a_chk, s_chk;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Counter stand-in: rco rises on the falling edge after a wrap and drops on the next rising edge.
   always @(posedge clk or negedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 4'd0; ld <= 1'b0; wrp <= 1'b0; rco_r <= 1'b0;
      end else if (clk) begin
         rco_r <= 1'b0;
         ld    <= 1'b0;
         wrp   <= 1'b0;
         if (enable) begin
            case (mode)
               2'd0: begin cnt <= cnt + 4'd1; wrp <= (cnt == 4'd15); end
               2'd1: begin cnt <= cnt - 4'd1; wrp <= (cnt == 4'd0); end
               2'd2: begin cnt <= cnt - 4'd3; wrp <= (cnt < 4'd3); end
               default: begin cnt <= D; ld <= 1'b1; end
            endcase
         end
      end else begin
         rco_r <= wrp & ~stuck;
      end
   end

   assign Q = cnt ^ (flip ? 4'b1000 : 4'b0000);

   contador_checker #(.ERR_CNT_W(8), .CHK_CNT_W(16), .STOP_ON_ERR(1'b0)) u_chk (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
      .Q(Q), .load(ld), .rco(rco_r), .exp_q(a_exp), .armed(a_armed),
      .err_q(a_eq), .err_load(a_el), .err_rco(a_er), .err(a_err),
      .err_count(a_errc), .chk_count(a_chk)
   );

   contador_checker #(.ERR_CNT_W(8), .CHK_CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
      .Q(Q), .load(ld), .rco(rco_r), .exp_q(s_exp), .armed(s_armed),
      .err_q(s_eq), .err_load(s_el), .err_rco(s_er), .err(s_err),
      .err_count(s_errc), .chk_count(s_chk)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) tick();
      check("rst_exp_q", a_exp, 0);
      check("rst_armed", a_armed, 0);
      check("rst_err", a_err, 0);
      check("rst_chk", a_chk, 0);
      check("rst_errc", a_errc, 0);
      reset = 1'b0; enable = 1'b1; mode = 2'd0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) begin
            check("arm_first_edge", a_armed, 1);
            check("chk_first_edge", a_chk, 0);
         end
         if (i == 15) check("up_15", a_exp, 15);
         if (i == 16) check("up_wrap0", a_exp, 0);
         if (i == 17) check("up_rco_ok", a_er, 0);
      end
      check("up_end", a_exp, 4);
      check("up_chk19", a_chk, 19);
      check("up_err", a_err, 0);
      mode = 2'd3; D = 4'b1010;
      tick();
      check("ld_exp", a_exp, 10);
      mode = 2'd1;
      tick();
      check("ld_cmp", a_el, 0);
      check("dn_9", a_exp, 9);
      tick();
      check("dn_8", a_exp, 8);
      check("ld_err", a_err, 0);
      repeat (6) tick();
      check("dn_2", a_exp, 2);
      mode = 2'd2;
      tick();
      check("d3_wrap", a_exp, 15);
      tick();
      check("d3_rco_ok", a_er, 0);
      check("d3_12", a_exp, 12);
      stuck = 1'b1;
      repeat (5) tick();
      check("d3_13", a_exp, 13);
      check("d3_noerr", a_err, 0);
      tick();
      check("rco_stuck_pulse", a_er, 1);
      check("rco_stuck_err", a_err, 1);
      check("rco_stuck_errc", a_errc, 1);
      check("rco_stuck_eq", a_eq, 0);
      tick();
      check("rco_pulse_end", a_er, 0);
      check("rco_err_sticky", a_err, 1);
      check("rco_errc_hold", a_errc, 1);
      check("rco_chk37", a_chk, 37);
      check("d3_7", a_exp, 7);
      enable = 1'b0; stuck = 1'b0;
      repeat (5) tick();
      check("hold_exp", a_exp, 7);
      check("hold_chk", a_chk, 42);
      check("hold_errc", a_errc, 1);
      check("hold_el", a_el, 0);
      check("hold_er", a_er, 0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_exp", a_exp, 0);
      check("mid_rst_armed", a_armed, 0);
      check("mid_rst_err", a_err, 0);
      check("mid_rst_errc", a_errc, 0);
      check("mid_rst_chk", a_chk, 0);
      check("mid_rst_s_err", s_err, 0);
      #14;
      reset = 1'b0; enable = 1'b1; mode = 2'd0;
      tick();
      check("rearm", a_armed, 1);
      check("rearm_chk", a_chk, 0);
      check("rearm_eq", a_eq, 0);
      check("rearm_err", a_err, 0);
      check("rearm_exp", a_exp, 1);
      tick();
      check("post_exp", a_exp, 2);
      check("post_chk", a_chk, 1);
      check("post_err", a_err, 0);
      check("post_s_exp", s_exp, 2);
      flip = 1'b1;
      tick();
      check("flip_eq", a_eq, 1);
      check("flip_errc", a_errc, 1);
      check("flip_s_eq", s_eq, 1);
      check("flip_s_errc", s_errc, 1);
      check("flip_s_chk", s_chk, 2);
      check("flip_s_exp", s_exp, 3);
      flip = 1'b0;
      tick();
      check("flip_eq_end", a_eq, 0);
      check("flip_errc_hold", a_errc, 1);
      check("flip_chk", a_chk, 3);
      check("stop_eq", s_eq, 0);
      check("stop_exp", s_exp, 3);
      check("stop_chk", s_chk, 2);
      check("stop_err", s_err, 1);
      flip = 1'b1;
      tick();
      check("flip2_eq", a_eq, 1);
      check("flip2_errc", a_errc, 2);
      check("stop2_errc", s_errc, 1);
      check("stop2_eq", s_eq, 0);
      flip = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
